// File: rtl/nn_pkg.sv
// nn_pkg: shared sizes, Q-format and loader state encoding for the hidden-layer front end
package nn_pkg;
   localparam int INPUT_SIZE = 784;
   localparam int ADDR_WIDTH = 10;
   localparam int PIX_W      = 8;
   localparam int Q_FRAC     = 15;
   typedef enum logic [1:0] {FILL, LAUNCH, WAIT} loader_state_t;
   function automatic logic [15:0] pix_to_q15(input logic [PIX_W-1:0] pix);
      return {1'b0, pix, {(Q_FRAC-PIX_W){1'b0}}};
   endfunction
endpackage

// File: rtl/input_loader_if.sv
// input_loader_if: valid/ready pixel stream carrying one pixel per beat with an end-of-frame marker
interface input_loader_if #(parameter int PIX_W = nn_pkg::PIX_W);
   logic             pix_valid;
   logic [PIX_W-1:0] pix_data;
   logic             pix_last;
   logic             pix_ready;
   modport master (output pix_valid, pix_data, pix_last, input pix_ready);
   modport slave  (input pix_valid, pix_data, pix_last, output pix_ready);
endinterface

// File: rtl/input_loader.sv
// input_loader: fills the Q1.15 input vector from a pixel stream, launches the hidden layer, holds until done
module input_loader #(
   parameter int INPUT_SIZE = nn_pkg::INPUT_SIZE,
   parameter int ADDR_WIDTH = nn_pkg::ADDR_WIDTH,
   parameter int PIX_W      = nn_pkg::PIX_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input_loader_if.slave        pix,
   output logic [15:0]          input_vector [INPUT_SIZE],
   output logic                 start,
   input  logic                 layer_done,
   output logic                 frame_err,
   output logic [15:0]          frame_cnt
);
   import nn_pkg::*;
   loader_state_t         state, state_nxt;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  beat, at_end;
   assign beat          = pix.pix_valid & pix.pix_ready;
   assign at_end        = idx == ADDR_WIDTH'(INPUT_SIZE-1);
   assign pix.pix_ready = state == FILL;
   assign start         = state == LAUNCH;
   always_comb begin
      state_nxt = state;
      state_nxt = (state == FILL && beat && at_end) ? LAUNCH :
                  (state == LAUNCH)                 ? WAIT   :
                  (state == WAIT && layer_done)     ? FILL   : state;
   end
   // a frame ends by count even without pix_last; an early pix_last just restarts the fill
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         idx       <= '0;
         frame_err <= 1'b0;
         frame_cnt <= '0;
      end else begin
         state     <= state_nxt;
         frame_err <= beat & (pix.pix_last != at_end);
         if (beat)
            idx <= (pix.pix_last || at_end) ? '0 : idx + 1'b1;
         if (start)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end
   always_ff @(posedge clk) begin
      if (rst)
         input_vector <= '{default: '0};
      else if (beat)
         input_vector[idx] <= {1'b0, pix.pix_data, {(Q_FRAC-PIX_W){1'b0}}};
   end
endmodule
